// File: rtl/button_debouncer.sv
// Debounces raw push-buttons on clk_in, using divided_clk rising edges as the sample tick.
// Each channel yields a clean level, a press pulse and a single long-press pulse per hold.
module button_debouncer #(
    parameter int N_BTN      = 4,
    parameter int DEB_TICKS  = 3,
    parameter int LONG_TICKS = 100,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             divided_clk,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             tick_out,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_C  = CNT_W'(DEB_TICKS);
    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_TICKS);

    // Counters stop at their limit instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        if (v >= lim) begin
            sat_inc = lim;
        end else begin
            sat_inc = v + ONE_C;
        end
    endfunction

    logic             div_meta_q, div_meta_d, div_sync_q, div_sync_d, div_prev_q, div_prev_d;
    logic [N_BTN-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic             tick_s, tick_out_q, tick_out_d;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CNT_W-1:0] dc_q [N_BTN];
    logic [CNT_W-1:0] dc_d [N_BTN];
    logic [CNT_W-1:0] hc_q [N_BTN];
    logic [CNT_W-1:0] hc_d [N_BTN];
    logic [CNT_W-1:0] dc_inc_s [N_BTN];
    logic [N_BTN-1:0] level_q, level_d, press_q, press_d, long_q, long_d;

    // Synchronizers, tick detection and per-channel next-state computation.
    always_comb begin
        div_meta_d = divided_clk;
        div_sync_d = div_meta_q;
        div_prev_d = div_sync_q;
        btn_meta_d = btn_raw;
        btn_sync_d = btn_meta_q;
        tick_s     = div_sync_q & ~div_prev_q;
        tick_out_d = tick_s;
        state_d    = state_q;
        dc_d       = dc_q;
        hc_d       = hc_q;
        level_d    = level_q;
        press_d    = {N_BTN{1'b0}};
        long_d     = {N_BTN{1'b0}};
        for (int i = 0; i < N_BTN; i++) begin
            dc_inc_s[i] = sat_inc(dc_q[i], DEB_C);
            if (tick_s) begin
                case (state_q[i])
                    IDLE: begin
                        if (btn_sync_q[i] && (DEB_C == ONE_C)) begin
                            state_d[i] = HELD;
                            dc_d[i]    = ZERO_C;
                            hc_d[i]    = ZERO_C;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else if (btn_sync_q[i]) begin
                            state_d[i] = PRESS_CHK;
                            dc_d[i]    = ONE_C;
                        end else begin
                            state_d[i] = IDLE;
                        end
                    end
                    PRESS_CHK: begin
                        if (!btn_sync_q[i]) begin
                            state_d[i] = IDLE;
                            dc_d[i]    = ZERO_C;
                        end else if (dc_inc_s[i] == DEB_C) begin
                            state_d[i] = HELD;
                            dc_d[i]    = ZERO_C;
                            hc_d[i]    = ZERO_C;
                            level_d[i] = 1'b1;
                            press_d[i] = 1'b1;
                        end else begin
                            dc_d[i]    = dc_inc_s[i];
                        end
                    end
                    HELD: begin
                        if (btn_sync_q[i]) begin
                            hc_d[i]   = sat_inc(hc_q[i], LONG_C);
                            long_d[i] = (hc_q[i] != LONG_C) && ((hc_q[i] + ONE_C) == LONG_C);
                        end else if (DEB_C == ONE_C) begin
                            state_d[i] = IDLE;
                            dc_d[i]    = ZERO_C;
                            hc_d[i]    = ZERO_C;
                            level_d[i] = 1'b0;
                        end else begin
                            state_d[i] = REL_CHK;
                            dc_d[i]    = ONE_C;
                        end
                    end
                    REL_CHK: begin
                        // A sample that agrees with "pressed" cancels the release; hc is kept.
                        if (btn_sync_q[i]) begin
                            state_d[i] = HELD;
                            dc_d[i]    = ZERO_C;
                        end else if (dc_inc_s[i] == DEB_C) begin
                            state_d[i] = IDLE;
                            dc_d[i]    = ZERO_C;
                            hc_d[i]    = ZERO_C;
                            level_d[i] = 1'b0;
                        end else begin
                            dc_d[i]    = dc_inc_s[i];
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        dc_d[i]    = ZERO_C;
                        hc_d[i]    = ZERO_C;
                        level_d[i] = 1'b0;
                    end
                endcase
            end else begin
                state_d[i] = state_q[i];
            end
        end
    end

    // State and output registers, cleared asynchronously by rst.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_meta_q <= 1'b0;
            div_sync_q <= 1'b0;
            div_prev_q <= 1'b0;
            btn_meta_q <= {N_BTN{1'b0}};
            btn_sync_q <= {N_BTN{1'b0}};
            tick_out_q <= 1'b0;
            level_q    <= {N_BTN{1'b0}};
            press_q    <= {N_BTN{1'b0}};
            long_q     <= {N_BTN{1'b0}};
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                dc_q[i]    <= ZERO_C;
                hc_q[i]    <= ZERO_C;
            end
        end else begin
            div_meta_q <= div_meta_d;
            div_sync_q <= div_sync_d;
            div_prev_q <= div_prev_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            tick_out_q <= tick_out_d;
            level_q    <= level_d;
            press_q    <= press_d;
            long_q     <= long_d;
            state_q    <= state_d;
            dc_q       <= dc_d;
            hc_q       <= hc_d;
        end
    end

    assign tick_out  = tick_out_q;
    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_long  = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: expected per-tick press/long/level events are
// queued as buttons are driven and compared when the corresponding tick reaches the outputs.
module tb_button_debouncer;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       divided_clk;
    logic [3:0] btn_raw;
    logic       tick_out;
    logic [3:0] btn_level, btn_press, btn_long;

    button_debouncer #(
        .N_BTN(4), .DEB_TICKS(3), .LONG_TICKS(5), .CNT_W(8)
    ) dut (
        .clk_in(clk_in), .rst(rst), .divided_clk(divided_clk), .btn_raw(btn_raw),
        .tick_out(tick_out), .btn_level(btn_level), .btn_press(btn_press), .btn_long(btn_long)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         tick;
        logic [3:0] press;
        logic [3:0] lng;
        logic [3:0] level;
    } sb_t;

    sb_t        sb_q[$];
    int         tick_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         drv_tick = 0;
    int         seen_tick = 0;
    int         div_phase = 0;
    logic       div_run = 1'b0;
    logic [3:0] exp_level = 4'b0000;
    int         base;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_exp(input int t, input logic [3:0] p, input logic [3:0] l,
                            input logic [3:0] lv);
        sb_t e;
        e.tick = t; e.press = p; e.lng = l; e.level = lv;
        sb_q.push_back(e);
    endtask

    task automatic wait_falls(input int n);
        repeat (n) @(negedge divided_clk);
    endtask

    // Per falling clk_in edge: compare outputs, then advance the divided_clk generator.
    initial begin
        logic       exp_tick;
        logic [3:0] ep, el;
        sb_t        e;
        forever begin
            @(negedge clk_in);
            cyc++;
            exp_tick = 1'b0;
            ep = 4'b0000;
            el = 4'b0000;
            if (tick_q.size() > 0 && tick_q[0] == cyc) begin
                void'(tick_q.pop_front());
                exp_tick = 1'b1;
                seen_tick++;
            end
            if (exp_tick && sb_q.size() > 0 && sb_q[0].tick == seen_tick) begin
                e = sb_q.pop_front();
                ep = e.press;
                el = e.lng;
                exp_level = e.level;
            end
            if (rst) exp_level = 4'b0000;
            chk_val("tick_out", 32'(tick_out), 32'(exp_tick));
            chk_val("btn_press", 32'(btn_press), 32'(ep));
            chk_val("btn_long", 32'(btn_long), 32'(el));
            chk_val("btn_level", 32'(btn_level), 32'(exp_level));
            if (div_run) begin
                div_phase++;
                if (div_phase == 10) begin
                    div_phase = 0;
                    divided_clk = ~divided_clk;
                    if (divided_clk) begin
                        drv_tick++;
                        tick_q.push_back(cyc + 3);
                    end
                end
            end else begin
                div_phase = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        btn_raw = 4'b0000;
        divided_clk = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_val("reset_level", 32'(btn_level), 32'd0);
        chk_val("reset_tick", 32'(tick_out), 32'd0);
        #2 rst = 1'b0;
        #1 div_run = 1'b1;

        // Clean press on channel 0, which also reaches a long press while held.
        wait_falls(1);
        base = drv_tick;
        btn_raw[0] = 1'b1;
        push_exp(base + 3, 4'b0001, 4'b0000, 4'b0001);
        push_exp(base + 8, 4'b0000, 4'b0001, 4'b0001);
        wait_falls(10);

        // One-tick release glitch, then a real three-tick release.
        base = drv_tick;
        btn_raw[0] = 1'b0;
        wait_falls(1);
        btn_raw[0] = 1'b1;
        wait_falls(3);
        base = drv_tick;
        btn_raw[0] = 1'b0;
        push_exp(base + 3, 4'b0000, 4'b0000, 4'b0000);
        wait_falls(5);

        // Bouncing channel 1 never holds for three consecutive ticks.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (i % 3 == 0) btn_raw[1] = ~btn_raw[1];
        end
        btn_raw[1] = 1'b0;
        wait_falls(5);

        // Long press on channel 2 for 12 ticks, then release.
        wait_falls(1);
        base = drv_tick;
        btn_raw[2] = 1'b1;
        push_exp(base + 3, 4'b0100, 4'b0000, 4'b0100);
        push_exp(base + 8, 4'b0000, 4'b0100, 4'b0100);
        wait_falls(12);
        base = drv_tick;
        btn_raw[2] = 1'b0;
        push_exp(base + 3, 4'b0000, 4'b0000, 4'b0000);
        wait_falls(5);

        // Simultaneous press on channels 0, 1 and 3.
        base = drv_tick;
        btn_raw = 4'b1011;
        push_exp(base + 3, 4'b1011, 4'b0000, 4'b1011);
        push_exp(base + 8, 4'b0000, 4'b1011, 4'b1011);
        wait_falls(10);

        // Freeze divided_clk low, then reset while the buttons are still held.
        div_run = 1'b0;
        repeat (2) @(negedge clk_in);
        #2 rst = 1'b1;
        #1;
        chk_val("rst_async_level", 32'(btn_level), 32'd0);
        chk_val("rst_async_press", 32'(btn_press), 32'd0);
        chk_val("rst_async_long", 32'(btn_long), 32'd0);
        chk_val("rst_async_tick", 32'(tick_out), 32'd0);
        @(negedge clk_in);
        #2 rst = 1'b0;
        repeat (60) @(negedge clk_in);
        #1 div_run = 1'b1;
        base = drv_tick;
        push_exp(base + 3, 4'b1011, 4'b0000, 4'b1011);
        push_exp(base + 8, 4'b0000, 4'b1011, 4'b1011);
        wait_falls(10);
        base = drv_tick;
        btn_raw = 4'b0000;
        push_exp(base + 3, 4'b0000, 4'b0000, 4'b0000);
        wait_falls(5);

        for (int k = 0; k < 300 && sb_q.size() != 0; k++) @(negedge clk_in);
        chk_val("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
